// File: rtl/emd_pixel_engine.sv
// EMD steganography engine: embeds message digits into groups of CHANNELS pixels
// (at most one pixel moved by +/-1 per group) or extracts them back into bytes.
module emd_pixel_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int DIGIT_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_empty,
    output logic                  pix_rd,
    input  logic [DATA_WIDTH-1:0] msg_data,
    input  logic                  msg_empty,
    output logic                  msg_rd,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    output logic                  busy,
    output logic [15:0]           grp_count
);

    localparam int M    = 2 * CHANNELS + 1;
    localparam int D    = DATA_WIDTH / DIGIT_BITS;
    localparam int ACCW = DATA_WIDTH + 8;
    localparam int MW   = $clog2(M + 1);
    localparam int IW   = (D > 1) ? $clog2(D) : 1;
    localparam int CW   = $clog2(CHANNELS);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_PIX, S_RD_MSG, S_CLAMP, S_CALC,
        S_ADJUST, S_WR_PIX, S_ACCUM, S_WR_MSG
    } state_t;

    state_t                state, state_next;
    logic                  mode_q;
    logic                  pend;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] msg_q;
    logic [DATA_WIDTH-1:0] ext_q;
    logic [DATA_WIDTH-1:0] g [CHANNELS];
    logic [MW-1:0]         s_q;
    logic [ACCW-1:0]       sum;
    logic [MW-1:0]         f;
    logic [DIGIT_BITS-1:0] digit;
    logic [MW-1:0]         s_calc;

    wire cnt_last = (cnt == CW'(CHANNELS - 1));
    wire idx_last = (idx == IW'(D - 1));

    // Weighted pixel sum, its residue mod M, and the embed shift s
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < CHANNELS; i++)
            sum = sum + ACCW'(g[i]) * ACCW'(i + 1);
        f      = MW'(sum % ACCW'(M));
        digit  = DIGIT_BITS'(msg_q >> (DATA_WIDTH - DIGIT_BITS * (int'(idx) + 1)));
        s_calc = MW'((ACCW'(digit) + ACCW'(M) - ACCW'(f)) % ACCW'(M));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pix_rd     = 1'b0;
        msg_rd     = 1'b0;
        out_wr     = 1'b0;
        out_data   = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!pix_empty && (mode || idx != '0 || !msg_empty))
                    state_next = S_RD_PIX;
            end
            S_RD_PIX: begin
                if (pend) begin
                    if (cnt_last)
                        state_next = mode_q ? S_CALC : ((idx == '0) ? S_RD_MSG : S_CLAMP);
                end else if (!pix_empty) begin
                    pix_rd = 1'b1;
                end
            end
            S_RD_MSG: begin
                if (pend)            state_next = S_CLAMP;
                else if (!msg_empty) msg_rd = 1'b1;
            end
            S_CLAMP:  state_next = S_CALC;
            S_CALC:   state_next = mode_q ? S_ACCUM : S_ADJUST;
            S_ADJUST: state_next = S_WR_PIX;
            S_WR_PIX: begin
                if (!out_full) begin
                    out_wr   = 1'b1;
                    out_data = g[cnt];
                    if (cnt_last) state_next = S_IDLE;
                end
            end
            S_ACCUM:  state_next = idx_last ? S_WR_MSG : S_IDLE;
            S_WR_MSG: begin
                if (!out_full) begin
                    out_wr     = 1'b1;
                    out_data   = ext_q;
                    state_next = S_IDLE;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            pend      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            msg_q     <= '0;
            ext_q     <= '0;
            s_q       <= '0;
            grp_count <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) g[i] <= '0;
        end else begin
            if (state == S_IDLE) mode_q <= mode;
            if (pix_rd || msg_rd) pend <= 1'b1;
            case (state)
                S_RD_PIX: if (pend) begin
                    g[cnt] <= pix_data;
                    pend   <= 1'b0;
                    cnt    <= cnt_last ? '0 : cnt + CW'(1);
                end
                S_RD_MSG: if (pend) begin
                    msg_q <= msg_data;
                    pend  <= 1'b0;
                end
                S_CLAMP: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (g[i] == '0)      g[i] <= DATA_WIDTH'(1);
                        else if (g[i] == '1) g[i] <= {{(DATA_WIDTH-1){1'b1}}, 1'b0};
                    end
                end
                S_CALC: s_q <= mode_q ? f : s_calc;
                // s in 1..N raises g_s; s above N lowers g_(M-s)
                S_ADJUST: begin
                    for (int unsigned i = 0; i < CHANNELS; i++) begin
                        if (32'(s_q) == i + 1)
                            g[i] <= g[i] + 1'b1;
                        else if (32'(s_q) > 32'(CHANNELS) && 32'(M) - 32'(s_q) == i + 1)
                            g[i] <= g[i] - 1'b1;
                    end
                end
                S_WR_PIX: if (!out_full) begin
                    if (cnt_last) begin
                        cnt       <= '0;
                        idx       <= idx_last ? '0 : idx + IW'(1);
                        grp_count <= grp_count + 16'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ACCUM: begin
                    ext_q     <= (ext_q << DIGIT_BITS) | DATA_WIDTH'(s_q[DIGIT_BITS-1:0]);
                    grp_count <= grp_count + 16'd1;
                    if (!idx_last) idx <= idx + IW'(1);
                end
                S_WR_MSG: if (!out_full) idx <= '0;
                default: ;
            endcase
        end
    end

endmodule
